// File: rtl/branch_predictor_pkg.sv
// Shared types and helpers for the fetch-side branch predictor.
package branch_predictor_pkg;

  localparam int unsigned BP_IDX_W = 6;

  // 2-bit saturating counter states; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_cnt_e;

  // Sequential next PC, wraps modulo 2^32.
  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch request, prediction response, execute update and statistics bundle.
interface branch_predictor_if;

  logic        i_Fetch_Valid;
  logic [31:0] i_Fetch_PC;
  logic        i_Stall;
  logic        o_Pred_Valid;
  logic        o_Pred_Taken;
  logic [31:0] o_Pred_Target;
  logic        i_Upd_Valid;
  logic [31:0] i_Upd_PC;
  logic        i_Upd_Taken;
  logic [31:0] i_Upd_Target;
  logic        i_Upd_Pred_Taken;
  logic [31:0] i_Upd_Pred_Target;
  logic        o_Mispredict;
  logic [31:0] o_Redirect_PC;
  logic [31:0] o_Br_Count;
  logic [31:0] o_Miss_Count;

  // Predictor side.
  modport slave (
    input  i_Fetch_Valid, i_Fetch_PC, i_Stall,
    output o_Pred_Valid, o_Pred_Taken, o_Pred_Target,
    input  i_Upd_Valid, i_Upd_PC, i_Upd_Taken, i_Upd_Target,
    input  i_Upd_Pred_Taken, i_Upd_Pred_Target,
    output o_Mispredict, o_Redirect_PC, o_Br_Count, o_Miss_Count
  );

  // Pipeline (fetch/execute) side.
  modport master (
    output i_Fetch_Valid, i_Fetch_PC, i_Stall,
    input  o_Pred_Valid, o_Pred_Taken, o_Pred_Target,
    output i_Upd_Valid, i_Upd_PC, i_Upd_Taken, i_Upd_Target,
    output i_Upd_Pred_Taken, i_Upd_Pred_Target,
    input  o_Mispredict, o_Redirect_PC, o_Br_Count, o_Miss_Count
  );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module bp_sat_counter2
  import branch_predictor_pkg::*;
(
  input  bp_cnt_e state,
  input  logic    taken,
  output bp_cnt_e next_state
);

  // Step toward ST on taken, toward SNT on not taken; saturate at both ends.
  always_comb begin
    next_state = state;
    case (state)
      BP_SNT:  next_state = taken ? BP_WNT : BP_SNT;
      BP_WNT:  next_state = taken ? BP_WT  : BP_SNT;
      BP_WT:   next_state = taken ? BP_ST  : BP_WNT;
      BP_ST:   next_state = taken ? BP_ST  : BP_WT;
      default: next_state = BP_WNT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped bimodal predictor with BTB, mispredict detection and stats.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = 2 ** BP_IDX_W,
  parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES)
) (
  input logic                i_Clk,
  input logic                i_Rst_n,
  branch_predictor_if.slave  bp
);

  localparam int unsigned TAG_W = 30 - IDX_W;

  bp_cnt_e          cnt_q       [BHT_ENTRIES];
  logic             btb_valid_q [BHT_ENTRIES];
  logic [TAG_W-1:0] btb_tag_q   [BHT_ENTRIES];
  logic [29:0]      btb_tgt_q   [BHT_ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             fetch_hit;
  logic             fetch_taken;
  logic [31:0]      fetch_target;
  bp_cnt_e          upd_cnt_next;
  logic             upd_mis;
  logic [31:0]      upd_redirect;
  logic [31:0]      br_count_q;
  logic [31:0]      miss_count_q;

  assign fetch_idx = bp.i_Fetch_PC[IDX_W+1:2];
  assign fetch_tag = bp.i_Fetch_PC[31:IDX_W+2];
  assign upd_idx   = bp.i_Upd_PC[IDX_W+1:2];
  assign upd_tag   = bp.i_Upd_PC[31:IDX_W+2];

  assign bp.o_Br_Count   = br_count_q;
  assign bp.o_Miss_Count = miss_count_q;

  bp_sat_counter2 u_sat_counter (
    .state      (cnt_q[upd_idx]),
    .taken      (bp.i_Upd_Taken),
    .next_state (upd_cnt_next)
  );

  // Prediction lookup on the pre-update table contents.
  always_comb begin
    fetch_hit    = btb_valid_q[fetch_idx] && (btb_tag_q[fetch_idx] == fetch_tag);
    fetch_taken  = fetch_hit && cnt_q[fetch_idx][1];
    fetch_target = fetch_taken ? {btb_tgt_q[fetch_idx], 2'b00} : pc_next(bp.i_Fetch_PC);
  end

  // Resolved-branch mispredict check and correct next PC.
  always_comb begin
    upd_mis      = (bp.i_Upd_Taken != bp.i_Upd_Pred_Taken) ||
                   (bp.i_Upd_Taken && (bp.i_Upd_Target != bp.i_Upd_Pred_Target));
    upd_redirect = bp.i_Upd_Taken ? bp.i_Upd_Target : pc_next(bp.i_Upd_PC);
  end

  // Counter and BTB valid arrays; only these need reset.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) begin
        cnt_q[i]       <= BP_WNT;
        btb_valid_q[i] <= 1'b0;
      end
    end else if (bp.i_Upd_Valid) begin
      cnt_q[upd_idx] <= upd_cnt_next;
      if (bp.i_Upd_Taken) btb_valid_q[upd_idx] <= 1'b1;
    end
  end

  // BTB tag/target storage; a write landing during reset is harmless
  // because the entry's valid bit is held clear.
  always_ff @(posedge i_Clk) begin
    if (bp.i_Upd_Valid && bp.i_Upd_Taken) begin
      btb_tag_q[upd_idx] <= upd_tag;
      btb_tgt_q[upd_idx] <= bp.i_Upd_Target[31:2];
    end
  end

  // Registered prediction outputs, frozen while fetch is stalled.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bp.o_Pred_Valid  <= 1'b0;
      bp.o_Pred_Taken  <= 1'b0;
      bp.o_Pred_Target <= '0;
    end else if (!bp.i_Stall) begin
      bp.o_Pred_Valid <= bp.i_Fetch_Valid;
      if (bp.i_Fetch_Valid) begin
        bp.o_Pred_Taken  <= fetch_taken;
        bp.o_Pred_Target <= fetch_target;
      end
    end
  end

  // One-cycle mispredict pulse with redirect target.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      bp.o_Mispredict  <= 1'b0;
      bp.o_Redirect_PC <= '0;
    end else begin
      bp.o_Mispredict <= bp.i_Upd_Valid && upd_mis;
      if (bp.i_Upd_Valid) bp.o_Redirect_PC <= upd_redirect;
    end
  end

  // Saturating resolved-branch and mispredict counters.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else if (bp.i_Upd_Valid) begin
      if (br_count_q != '1) br_count_q <= br_count_q + 32'd1;
      if (upd_mis && (miss_count_q != '1)) miss_count_q <= miss_count_q + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor using an expectation scoreboard.
module tb_branch_predictor;

  localparam int unsigned NE = 64;
  localparam logic        Y  = 1'b1;
  localparam logic        O  = 1'b0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int unsigned total = 0;
  int unsigned bad   = 0;

  logic [31:0] exp_br   = '0;
  logic [31:0] exp_miss = '0;

  typedef struct packed {
    logic        v;
    logic        t;
    logic [31:0] tgt;
  } pexp_t;

  typedef struct packed {
    logic        m;
    logic [31:0] pc;
  } mexp_t;

  // Columns: stall, fv, fpc, uv, upc, ut, utgt, upt, uptgt | exp: pv, pt, ptgt, mis, rpc
  typedef struct {
    logic        stall;
    logic        fv;
    logic [31:0] fpc;
    logic        uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        upt;
    logic [31:0] uptgt;
    logic        xv;
    logic        xt;
    logic [31:0] xtgt;
    logic        xm;
    logic [31:0] xrpc;
  } step_t;

  pexp_t pred_q[$];
  mexp_t mis_q[$];

  branch_predictor_if bus ();

  branch_predictor #(.BHT_ENTRIES(NE)) dut (
    .i_Clk   (clk),
    .i_Rst_n (rst_n),
    .bp      (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs;
    bus.i_Stall = 0; bus.i_Fetch_Valid = 0; bus.i_Fetch_PC = '0;
    bus.i_Upd_Valid = 0; bus.i_Upd_PC = '0; bus.i_Upd_Taken = 0;
    bus.i_Upd_Target = '0; bus.i_Upd_Pred_Taken = 0; bus.i_Upd_Pred_Target = '0;
  endtask

  // Drive one cycle of stimulus and record what the DUT must show after the edge.
  task automatic apply(input step_t x);
    bus.i_Stall = x.stall; bus.i_Fetch_Valid = x.fv; bus.i_Fetch_PC = x.fpc;
    bus.i_Upd_Valid = x.uv; bus.i_Upd_PC = x.upc; bus.i_Upd_Taken = x.ut;
    bus.i_Upd_Target = x.utgt; bus.i_Upd_Pred_Taken = x.upt; bus.i_Upd_Pred_Target = x.uptgt;
    pred_q.push_back('{x.xv, x.xt, x.xtgt});
    mis_q.push_back('{x.xm, x.xrpc});
    if (x.uv) begin
      exp_br = exp_br + 32'd1;
      if (x.xm) exp_miss = exp_miss + 32'd1;
    end
  endtask

  task automatic test_reset;
    idle_inputs();
    #1;
    total++;
    if ({bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target} !== 34'd0) begin
      bad++; $display("FAIL reset_pred: got v=%b t=%b tgt=%h, want all 0", bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target);
    end
    total++;
    if ({bus.o_Mispredict, bus.o_Redirect_PC, bus.o_Br_Count, bus.o_Miss_Count} !== 97'd0) begin
      bad++; $display("FAIL reset_upd: got mis=%b rpc=%h br=%h miss=%h, want all 0", bus.o_Mispredict, bus.o_Redirect_PC, bus.o_Br_Count, bus.o_Miss_Count);
    end
    // Activity while held in reset must not move anything.
    bus.i_Fetch_Valid = 1; bus.i_Fetch_PC = 32'h100;
    bus.i_Upd_Valid = 1; bus.i_Upd_PC = 32'h100; bus.i_Upd_Taken = 1; bus.i_Upd_Target = 32'h40;
    @(posedge clk); #1;
    total++;
    if ({bus.o_Pred_Valid, bus.o_Mispredict, bus.o_Br_Count} !== 34'd0) begin
      bad++; $display("FAIL reset_hold: got pv=%b mis=%b br=%h, want 0 0 0", bus.o_Pred_Valid, bus.o_Mispredict, bus.o_Br_Count);
    end
    idle_inputs();
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_train;
    step_t s[$];
    pexp_t ep;
    mexp_t em;
    s.push_back('{O, Y, 32'h100, O, 32'h0,   O, 32'h0,  O, 32'h0,  Y, O, 32'h104, O, 32'h0});
    s.push_back('{O, O, 32'h0,   Y, 32'h100, Y, 32'h40, O, 32'h0,  O, O, 32'h0,   Y, 32'h40});
    s.push_back('{O, Y, 32'h100, O, 32'h0,   O, 32'h0,  O, 32'h0,  Y, Y, 32'h40,  O, 32'h0});
    s.push_back('{O, O, 32'h0,   Y, 32'h100, O, 32'h0,  Y, 32'h40, O, O, 32'h0,   Y, 32'h104});
    s.push_back('{O, O, 32'h0,   Y, 32'h100, O, 32'h0,  O, 32'h0,  O, O, 32'h0,   O, 32'h0});
    s.push_back('{O, Y, 32'h100, O, 32'h0,   O, 32'h0,  O, 32'h0,  Y, O, 32'h104, O, 32'h0});
    s.push_back('{O, O, 32'h0,   Y, 32'h100, O, 32'h0,  O, 32'h0,  O, O, 32'h0,   O, 32'h0});
    s.push_back('{O, O, 32'h0,   Y, 32'h100, Y, 32'h40, O, 32'h0,  O, O, 32'h0,   Y, 32'h40});
    s.push_back('{O, Y, 32'h100, O, 32'h0,   O, 32'h0,  O, 32'h0,  Y, O, 32'h104, O, 32'h0});
    foreach (s[k]) begin
      apply(s[k]);
      @(posedge clk); #1;
      ep = pred_q.pop_front();
      em = mis_q.pop_front();
      total++;
      if (ep.v ? ({bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target} !== {ep.v, ep.t, ep.tgt}) : (bus.o_Pred_Valid !== 1'b0)) begin
        bad++; $display("FAIL train[%0d] pred: got v=%b t=%b tgt=%h, want v=%b t=%b tgt=%h", k, bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target, ep.v, ep.t, ep.tgt);
      end
      total++;
      if (em.m ? ({bus.o_Mispredict, bus.o_Redirect_PC} !== {1'b1, em.pc}) : (bus.o_Mispredict !== 1'b0)) begin
        bad++; $display("FAIL train[%0d] mispredict: got m=%b rpc=%h, want m=%b rpc=%h", k, bus.o_Mispredict, bus.o_Redirect_PC, em.m, em.pc);
      end
      total++;
      if ({bus.o_Br_Count, bus.o_Miss_Count} !== {exp_br, exp_miss}) begin
        bad++; $display("FAIL train[%0d] counts: got br=%0d miss=%0d, want br=%0d miss=%0d", k, bus.o_Br_Count, bus.o_Miss_Count, exp_br, exp_miss);
      end
    end
    idle_inputs();
  endtask

  task automatic test_alias_target;
    step_t s[$];
    pexp_t ep;
    mexp_t em;
    logic [31:0] alias_pc;
    alias_pc = 32'h100 + 4 * NE;
    s.push_back('{O, O, 32'h0,       Y, 32'h100,  Y, 32'h40,  O, 32'h0,   O, O, 32'h0,            Y, 32'h40});
    s.push_back('{O, Y, 32'h100,     O, 32'h0,    O, 32'h0,   O, 32'h0,   Y, Y, 32'h40,           O, 32'h0});
    s.push_back('{O, Y, alias_pc,    O, 32'h0,    O, 32'h0,   O, 32'h0,   Y, O, alias_pc + 32'd4, O, 32'h0});
    s.push_back('{O, O, 32'h0,       Y, 32'h100,  Y, 32'h80,  Y, 32'h40,  O, O, 32'h0,            Y, 32'h80});
    s.push_back('{O, Y, 32'h103,     O, 32'h0,    O, 32'h0,   O, 32'h0,   Y, Y, 32'h80,           O, 32'h0});
    s.push_back('{O, Y, 32'h200,     Y, 32'h200,  Y, 32'h300, O, 32'h0,   Y, O, 32'h204,          Y, 32'h300});
    s.push_back('{O, Y, 32'h200,     O, 32'h0,    O, 32'h0,   O, 32'h0,   Y, Y, 32'h300,          O, 32'h0});
    s.push_back('{O, Y, 32'h100,     O, 32'h0,    O, 32'h0,   O, 32'h0,   Y, O, 32'h104,          O, 32'h0});
    s.push_back('{O, Y, 32'hFFFFFFFC, O, 32'h0,   O, 32'h0,   O, 32'h0,   Y, O, 32'h0,            O, 32'h0});
    s.push_back('{O, O, 32'h0,       Y, 32'h200,  Y, 32'h300, Y, 32'h300, O, O, 32'h0,            O, 32'h0});
    foreach (s[k]) begin
      apply(s[k]);
      @(posedge clk); #1;
      ep = pred_q.pop_front();
      em = mis_q.pop_front();
      total++;
      if (ep.v ? ({bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target} !== {ep.v, ep.t, ep.tgt}) : (bus.o_Pred_Valid !== 1'b0)) begin
        bad++; $display("FAIL alias[%0d] pred: got v=%b t=%b tgt=%h, want v=%b t=%b tgt=%h", k, bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target, ep.v, ep.t, ep.tgt);
      end
      total++;
      if (em.m ? ({bus.o_Mispredict, bus.o_Redirect_PC} !== {1'b1, em.pc}) : (bus.o_Mispredict !== 1'b0)) begin
        bad++; $display("FAIL alias[%0d] mispredict: got m=%b rpc=%h, want m=%b rpc=%h", k, bus.o_Mispredict, bus.o_Redirect_PC, em.m, em.pc);
      end
      total++;
      if ({bus.o_Br_Count, bus.o_Miss_Count} !== {exp_br, exp_miss}) begin
        bad++; $display("FAIL alias[%0d] counts: got br=%0d miss=%0d, want br=%0d miss=%0d", k, bus.o_Br_Count, bus.o_Miss_Count, exp_br, exp_miss);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back;
    step_t s[$];
    pexp_t ep;
    mexp_t em;
    s.push_back('{O, O, 32'h0,   Y, 32'h408, O, 32'h0,   O, 32'h0,   O, O, 32'h0,   O, 32'h0});
    s.push_back('{O, O, 32'h0,   Y, 32'h408, Y, 32'h500, O, 32'h0,   O, O, 32'h0,   Y, 32'h500});
    s.push_back('{O, O, 32'h0,   Y, 32'h40C, O, 32'h0,   Y, 32'h500, O, O, 32'h0,   Y, 32'h410});
    s.push_back('{O, O, 32'h0,   Y, 32'h408, Y, 32'h500, O, 32'h0,   O, O, 32'h0,   Y, 32'h500});
    s.push_back('{O, O, 32'h0,   O, 32'h0,   O, 32'h0,   O, 32'h0,   O, O, 32'h0,   O, 32'h0});
    s.push_back('{O, Y, 32'h408, O, 32'h0,   O, 32'h0,   O, 32'h0,   Y, Y, 32'h500, O, 32'h0});
    foreach (s[k]) begin
      apply(s[k]);
      @(posedge clk); #1;
      ep = pred_q.pop_front();
      em = mis_q.pop_front();
      total++;
      if (ep.v ? ({bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target} !== {ep.v, ep.t, ep.tgt}) : (bus.o_Pred_Valid !== 1'b0)) begin
        bad++; $display("FAIL b2b[%0d] pred: got v=%b t=%b tgt=%h, want v=%b t=%b tgt=%h", k, bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target, ep.v, ep.t, ep.tgt);
      end
      total++;
      if (em.m ? ({bus.o_Mispredict, bus.o_Redirect_PC} !== {1'b1, em.pc}) : (bus.o_Mispredict !== 1'b0)) begin
        bad++; $display("FAIL b2b[%0d] mispredict: got m=%b rpc=%h, want m=%b rpc=%h", k, bus.o_Mispredict, bus.o_Redirect_PC, em.m, em.pc);
      end
      total++;
      if ({bus.o_Br_Count, bus.o_Miss_Count} !== {exp_br, exp_miss}) begin
        bad++; $display("FAIL b2b[%0d] counts: got br=%0d miss=%0d, want br=%0d miss=%0d", k, bus.o_Br_Count, bus.o_Miss_Count, exp_br, exp_miss);
      end
    end
    idle_inputs();
  endtask

  task automatic test_stall;
    step_t s[$];
    pexp_t ep;
    mexp_t em;
    s.push_back('{O, Y, 32'h408, O, 32'h0,   O, 32'h0, O, 32'h0,   Y, Y, 32'h500, O, 32'h0});
    s.push_back('{Y, Y, 32'h100, Y, 32'h408, O, 32'h0, Y, 32'h500, Y, Y, 32'h500, Y, 32'h40C});
    s.push_back('{Y, O, 32'h0,   O, 32'h0,   O, 32'h0, O, 32'h0,   Y, Y, 32'h500, O, 32'h0});
    s.push_back('{Y, Y, 32'h200, O, 32'h0,   O, 32'h0, O, 32'h0,   Y, Y, 32'h500, O, 32'h0});
    s.push_back('{O, Y, 32'h408, O, 32'h0,   O, 32'h0, O, 32'h0,   Y, O, 32'h40C, O, 32'h0});
    s.push_back('{O, O, 32'h0,   O, 32'h0,   O, 32'h0, O, 32'h0,   O, O, 32'h0,   O, 32'h0});
    foreach (s[k]) begin
      apply(s[k]);
      @(posedge clk); #1;
      ep = pred_q.pop_front();
      em = mis_q.pop_front();
      total++;
      if (ep.v ? ({bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target} !== {ep.v, ep.t, ep.tgt}) : (bus.o_Pred_Valid !== 1'b0)) begin
        bad++; $display("FAIL stall[%0d] pred: got v=%b t=%b tgt=%h, want v=%b t=%b tgt=%h", k, bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target, ep.v, ep.t, ep.tgt);
      end
      total++;
      if (em.m ? ({bus.o_Mispredict, bus.o_Redirect_PC} !== {1'b1, em.pc}) : (bus.o_Mispredict !== 1'b0)) begin
        bad++; $display("FAIL stall[%0d] mispredict: got m=%b rpc=%h, want m=%b rpc=%h", k, bus.o_Mispredict, bus.o_Redirect_PC, em.m, em.pc);
      end
      total++;
      if ({bus.o_Br_Count, bus.o_Miss_Count} !== {exp_br, exp_miss}) begin
        bad++; $display("FAIL stall[%0d] counts: got br=%0d miss=%0d, want br=%0d miss=%0d", k, bus.o_Br_Count, bus.o_Miss_Count, exp_br, exp_miss);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_update;
    bus.i_Fetch_Valid = 1; bus.i_Fetch_PC = 32'h408;
    bus.i_Upd_Valid = 1; bus.i_Upd_PC = 32'h408; bus.i_Upd_Taken = 1;
    bus.i_Upd_Target = 32'h700; bus.i_Upd_Pred_Taken = 0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target, bus.o_Mispredict, bus.o_Redirect_PC} !== 67'd0) begin
      bad++; $display("FAIL midreset_async: got pv=%b pt=%b tgt=%h mis=%b rpc=%h, want all 0", bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target, bus.o_Mispredict, bus.o_Redirect_PC);
    end
    total++;
    if ({bus.o_Br_Count, bus.o_Miss_Count} !== 64'd0) begin
      bad++; $display("FAIL midreset_counts: got br=%h miss=%h, want 0 0", bus.o_Br_Count, bus.o_Miss_Count);
    end
    @(posedge clk); #1;
    idle_inputs();
    rst_n = 1'b1;
    exp_br = '0;
    exp_miss = '0;
    @(posedge clk); #1;
    bus.i_Fetch_Valid = 1; bus.i_Fetch_PC = 32'h408;
    @(posedge clk); #1;
    total++;
    if ({bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target} !== {1'b1, 1'b0, 32'h40C}) begin
      bad++; $display("FAIL midreset_lost: got v=%b t=%b tgt=%h, want v=1 t=0 tgt=0000040c", bus.o_Pred_Valid, bus.o_Pred_Taken, bus.o_Pred_Target);
    end
    total++;
    if ({bus.o_Br_Count, bus.o_Miss_Count} !== 64'd0) begin
      bad++; $display("FAIL midreset_stats: got br=%h miss=%h, want 0 0", bus.o_Br_Count, bus.o_Miss_Count);
    end
    idle_inputs();
  endtask

  task automatic test_saturation;
    step_t s[$];
    pexp_t ep;
    mexp_t em;
    force dut.br_count_q = 32'hFFFFFFFE;
    force dut.miss_count_q = 32'hFFFFFFFE;
    #1;
    release dut.br_count_q;
    release dut.miss_count_q;
    s.push_back('{O, O, 32'h0, Y, 32'h10, Y, 32'h20, O, 32'h0,  O, O, 32'h0, Y, 32'h20});
    s.push_back('{O, O, 32'h0, Y, 32'h10, Y, 32'h20, O, 32'h0,  O, O, 32'h0, Y, 32'h20});
    s.push_back('{O, O, 32'h0, Y, 32'h10, Y, 32'h20, Y, 32'h20, O, O, 32'h0, O, 32'h0});
    foreach (s[k]) begin
      apply(s[k]);
      @(posedge clk); #1;
      ep = pred_q.pop_front();
      em = mis_q.pop_front();
      total++;
      if (em.m ? ({bus.o_Mispredict, bus.o_Redirect_PC} !== {1'b1, em.pc}) : (bus.o_Mispredict !== 1'b0)) begin
        bad++; $display("FAIL sat[%0d] mispredict: got m=%b rpc=%h, want m=%b rpc=%h", k, bus.o_Mispredict, bus.o_Redirect_PC, em.m, em.pc);
      end
      total++;
      if ({bus.o_Br_Count, bus.o_Miss_Count, ep.v} !== {32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0}) begin
        bad++; $display("FAIL sat[%0d] counts: got br=%h miss=%h, want br=ffffffff miss=ffffffff", k, bus.o_Br_Count, bus.o_Miss_Count);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_train();
    test_alias_target();
    test_back_to_back();
    test_stall();
    test_reset_mid_update();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Fetch-side dynamic branch predictor. It is the counterpart to the execute-stage branch decision logic.
- Predicts taken/not-taken and the target for the PC being fetched.
- Consumes the resolved outcome from execute: actual taken (branch decision output), actual target, and the prediction that travelled down the pipe.
- On a mismatch it raises a one-cycle mispredict pulse and a redirect PC, which fetch uses to flush.

Parameters:
- BHT_ENTRIES, 64, number of direct-mapped entries (power of two, ≥4).
- IDX_W, $clog2(BHT_ENTRIES), index width.

Ports:
- i_Clk  input  1  core clock.
- i_Rst_n  input  1  asynchronous active-low reset.
- i_Fetch_Valid  input  1  fetch PC valid this cycle.
- i_Fetch_PC  input  32  PC being fetched.
- i_Stall  input  1  fetch stalled; hold prediction outputs.
- o_Pred_Valid  output  1  prediction outputs valid.
- o_Pred_Taken  output  1  predicted taken.
- o_Pred_Target  output  32  predicted target; PC+4 when not taken.
- i_Upd_Valid  input  1  a conditional branch resolved this cycle.
- i_Upd_PC  input  32  PC of the resolved branch.
- i_Upd_Taken  input  1  actual outcome from branch decision.
- i_Upd_Target  input  32  actual taken target.
- i_Upd_Pred_Taken  input  1  prediction made for this branch.
- i_Upd_Pred_Target  input  32  target predicted for this branch.
- o_Mispredict  output  1  one-cycle flush pulse.
- o_Redirect_PC  output  32  correct next PC; valid when o_Mispredict=1.
- o_Br_Count  output  32  resolved-branch counter (saturating).
- o_Miss_Count  output  32  mispredict counter (saturating).

Behaviour:
- Reset (async, i_Rst_n=0):
  - All counters go to WNT (2'b01); all BTB valid bits go to 0.
  - o_Pred_Valid=0, o_Pred_Taken=0, o_Pred_Target=0.
  - o_Mispredict=0, o_Redirect_PC=0, o_Br_Count=0, o_Miss_Count=0.
  - Reset mid-update discards that update entirely.
- Address split:
  - index = PC[IDX_W+1:2].
  - tag = PC[31:IDX_W+2].
  - PC[1:0] is ignored.
- Storage per entry:
  - 2-bit counter (untagged).
  - BTB valid bit, tag, and 30-bit target (target[1:0] stored as 0).
- Prediction, latency 1 cycle (registered read):
  - Sample i_Fetch_PC when i_Fetch_Valid=1 and i_Stall=0.
  - Next cycle: o_Pred_Valid=1.
  - o_Pred_Taken = BTB hit (valid and tag match) AND counter[1].
  - o_Pred_Target = stored target if o_Pred_Taken=1, else sampled PC+4 (wraps modulo 2^32).
  - i_Fetch_Valid=0 with i_Stall=0: o_Pred_Valid=0 next cycle.
  - i_Stall=1: all prediction outputs hold their values.
- Update (i_Upd_Valid=1), applied at the clock edge:
  - Counter at the update index: taken → saturating increment (ST stays ST); not taken → saturating decrement (SNT stays SNT).
  - If i_Upd_Taken=1: write BTB valid=1, tag, and target; replaces any existing entry.
  - Not-taken branches never allocate or invalidate BTB entries.
- Mispredict, latency 1 cycle:
  - mis = (i_Upd_Taken != i_Upd_Pred_Taken) OR (i_Upd_Taken AND i_Upd_Target != i_Upd_Pred_Target).
  - Next cycle: o_Mispredict = mis.
  - o_Redirect_PC = i_Upd_Target if taken, else i_Upd_PC+4.
  - o_Mispredict is never asserted for two consecutive cycles unless two updates arrive back to back. Each update is evaluated independently.
- Statistics:
  - o_Br_Count increments on every update.
  - o_Miss_Count increments on every mispredicting update.
  - Both saturate at 32'hFFFFFFFF with no wrap.
- Simultaneous fetch and update to the same index: the prediction reads the pre-update state. No bypass.
- i_Stall does not block updates.

Decomposition:
- Add to parameters.vh: counter state constants `BP_SNT=2'b00, `BP_WNT=2'b01, `BP_WT=2'b10, `BP_ST=2'b11, and `BP_IDX_W default.
- One sub-module: bp_sat_counter2. It takes the current state and taken, and outputs the next state (pure next-state function, instantiated in the update path).
- Arrays are inferred in branch_predictor itself.

Test Plan:
- Reset, then fetch PC=0x100 → o_Pred_Valid=1, o_Pred_Taken=0, o_Pred_Target=0x104 one cycle later; both counts 0.
- Update PC=0x100, taken, target=0x40, pred_taken=0 → next cycle o_Mispredict=1, o_Redirect_PC=0x40, Br=1, Miss=1. Fetch 0x100 then yields taken/0x40 (counter WT).
- Two more not-taken updates at 0x100 (pred_taken=1 first) → counter WT→WNT→SNT. Fetch predicts not-taken/0x104. Third not-taken update leaves SNT, no mispredict when pred_taken=0.
- Alias: allocate 0x100 taken. Fetch 0x100+4*BHT_ENTRIES → tag miss, predicts not-taken even though counter[1]=1.
- Correct taken prediction with wrong target (pred 0x40, actual 0x80) → o_Mispredict=1, o_Redirect_PC=0x80. Same fetch/update cycle at 0x200 returns old state.
- Stall held 3 cycles → prediction outputs constant. Assert i_Rst_n low mid-update → all outputs 0 immediately and the update is lost. Saturation: preload counters near max → values hold at 32'hFFFFFFFF.
